// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_pkg
// Purpose  : Shared constants and types for the seven-segment display mux.
// Revision : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    typedef logic [DIGIT_W-1:0] nibble_t;
    typedef logic [6:0]         seg_t;

    // Active-low gfedcba patterns; entry n lives at SEG_TABLE[n].
    localparam seg_t [15:0] SEG_TABLE = {
        7'b0001110,     // F
        7'b0000110,     // E
        7'b0100001,     // D
        7'b1000110,     // C
        7'b0000011,     // B
        7'b0001000,     // A
        7'b0011000,     // 9
        7'b0000000,     // 8
        7'b1111000,     // 7
        7'b0000010,     // 6
        7'b0010010,     // 5
        7'b0011001,     // 4
        7'b0110000,     // 3
        7'b0100100,     // 2
        7'b1111001,     // 1
        7'b1000000      // 0
    };

endpackage
`default_nettype wire

// File: rtl/hex_to_seg.sv
`default_nettype none
// ============================================================================
// Module   : hex_to_seg
// Purpose  : Combinational hex nibble to active-low seven-segment decoder.
// Revision : 1.0 - initial release
// ============================================================================
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_nibble,
    output logic [6:0]         o_seg
);

    assign o_seg = SEG_TABLE[i_nibble];

endmodule
`default_nettype wire

// File: rtl/seven_seg_mux.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_mux
// Purpose  : Time-multiplexed hex display driver with frame-atomic updates.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_mux
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter int GUARD         = 2,
    parameter int ACTIVE_LOW_AN = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]         dp,
    input  logic [NUM_DIGITS-1:0]         blank,
    input  logic                          lz_en,
    input  logic                          load,
    output logic [6:0]                    segments,
    output logic                          dp_out,
    output logic [NUM_DIGITS-1:0]         anodes,
    output logic                          frame_done
);

    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRE_W-1:0]      c_pre_last = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      c_idx_last = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_an_off   = (ACTIVE_LOW_AN != 0) ? {NUM_DIGITS{1'b1}}
                                                                        : {NUM_DIGITS{1'b0}};

    logic [PRE_W-1:0]              r_pre;
    logic [IDX_W-1:0]              r_idx;
    logic [DIGIT_W*NUM_DIGITS-1:0] r_pend_value;
    logic [NUM_DIGITS-1:0]         r_pend_dp;
    logic [NUM_DIGITS-1:0]         r_pend_blank;
    logic                          r_pend_lz;
    logic [DIGIT_W*NUM_DIGITS-1:0] r_disp_value;
    logic [NUM_DIGITS-1:0]         r_disp_dp;
    logic [NUM_DIGITS-1:0]         r_disp_blank;
    logic                          r_disp_lz;

    logic                  w_slot_end;
    logic                  w_frame_end;
    logic [DIGIT_W-1:0]    w_nibble;
    logic [6:0]            w_seg;
    logic                  w_zero_acc;
    logic                  w_lz_dark;
    logic                  w_dark;
    logic                  w_in_guard;
    logic [NUM_DIGITS-1:0] w_an_next;

    assign w_slot_end  = (r_pre == c_pre_last);
    assign w_frame_end = w_slot_end && (r_idx == c_idx_last);
    assign frame_done  = w_frame_end;

    // A load on the wrap cycle bypasses pending so the new data lands in this frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre        <= '0;
            r_idx        <= '0;
            r_pend_value <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_pend_lz    <= 1'b0;
            r_disp_value <= '0;
            r_disp_dp    <= '0;
            r_disp_blank <= '0;
            r_disp_lz    <= 1'b0;
        end else begin
            if (load) begin
                r_pend_value <= value;
                r_pend_dp    <= dp;
                r_pend_blank <= blank;
                r_pend_lz    <= lz_en;
            end
            if (w_slot_end) begin
                r_pre <= '0;
                if (w_frame_end) begin
                    r_idx        <= '0;
                    r_disp_value <= load ? value : r_pend_value;
                    r_disp_dp    <= load ? dp    : r_pend_dp;
                    r_disp_blank <= load ? blank : r_pend_blank;
                    r_disp_lz    <= load ? lz_en : r_pend_lz;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

    assign w_nibble = r_disp_value[r_idx*DIGIT_W +: DIGIT_W];

    hex_to_seg u_hex_to_seg (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    // Walk from the top digit down: a digit is a leading zero if it and everything above is zero.
    always_comb begin
        w_zero_acc = 1'b1;
        w_lz_dark  = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_acc = w_zero_acc & (r_disp_value[i*DIGIT_W +: DIGIT_W] == '0);
            if (i == int'(r_idx)) begin
                w_lz_dark = w_zero_acc;
            end
        end
    end

    assign w_dark     = r_disp_blank[r_idx] | (r_disp_lz & w_lz_dark & (r_idx != '0));
    assign w_in_guard = (int'(r_pre) < GUARD);
    assign w_an_next  = w_in_guard ? '0 : (NUM_DIGITS'(1) << r_idx);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            segments <= SEG_OFF;
            dp_out   <= 1'b1;
            anodes   <= c_an_off;
        end else begin
            segments <= w_dark ? SEG_OFF : w_seg;
            dp_out   <= w_dark ? 1'b1 : ~r_disp_dp[r_idx];
            anodes   <= (ACTIVE_LOW_AN != 0) ? ~w_an_next : w_an_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_mux
// Purpose  : Directed self-checking bench for seven_seg_mux (4 digits, 8-cycle slots).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_mux;

    localparam int NUM_DIGITS  = 4;
    localparam int REFRESH_DIV = 8;
    localparam int GUARD       = 2;

    localparam logic [6:0] S0  = 7'b1000000;
    localparam logic [6:0] S1  = 7'b1111001;
    localparam logic [6:0] S2  = 7'b0100100;
    localparam logic [6:0] S4  = 7'b0011001;
    localparam logic [6:0] S5  = 7'b0010010;
    localparam logic [6:0] SA  = 7'b0001000;
    localparam logic [6:0] SF  = 7'b0001110;
    localparam logic [6:0] OFF = 7'b1111111;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp    = 4'b0000;
    logic [3:0]  blank = 4'b0000;
    logic        lz_en = 1'b0;
    logic        load  = 1'b0;
    logic [6:0]  segments;
    logic        dp_out;
    logic [3:0]  anodes;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seven_seg_mux #(
        .NUM_DIGITS    (NUM_DIGITS),
        .REFRESH_DIV   (REFRESH_DIV),
        .GUARD         (GUARD),
        .ACTIVE_LOW_AN (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .dp         (dp),
        .blank      (blank),
        .lz_en      (lz_en),
        .load       (load),
        .segments   (segments),
        .dp_out     (dp_out),
        .anodes     (anodes),
        .frame_done (frame_done)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %0s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " segments"},   {9'h0, segments},   {9'h0, OFF});
        chk({tag, " dp_out"},     {15'h0, dp_out},    16'h0001);
        chk({tag, " anodes"},     {12'h0, anodes},    16'h000F);
        chk({tag, " frame_done"}, {15'h0, frame_done}, 16'h0000);
    endtask

    // Entered one edge into a frame: outputs show slot (0,0). Walks all 32 cycles.
    task automatic check_frame(input string name, input logic [27:0] segs, input logic [3:0] dpo,
                               input int ld_d, input int ld_p, input logic [15:0] nv,
                               input logic [3:0] ndp, input logic [3:0] nbl, input logic nlz);
        logic [3:0] one;
        logic [3:0] exp_an;
        logic       exp_fd;
        one = 4'b0001;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            for (int p = 0; p < REFRESH_DIV; p++) begin
                exp_an = (p < GUARD) ? 4'b1111 : ~(one << d);
                exp_fd = (d == 3) && (p == REFRESH_DIV - 2);
                chk($sformatf("%0s anodes d%0d p%0d", name, d, p), {12'h0, anodes}, {12'h0, exp_an});
                chk($sformatf("%0s frame_done d%0d p%0d", name, d, p), {15'h0, frame_done}, {15'h0, exp_fd});
                if (p == GUARD) begin
                    chk($sformatf("%0s segments d%0d", name, d), {9'h0, segments}, {9'h0, segs[d*7 +: 7]});
                    chk($sformatf("%0s dp_out d%0d", name, d), {15'h0, dp_out}, {15'h0, dpo[d]});
                end
                if (d == ld_d && p == ld_p) begin
                    value = nv;
                    dp    = ndp;
                    blank = nbl;
                    lz_en = nlz;
                    load  = 1'b1;
                end
                step();
                load = 1'b0;
            end
        end
    endtask

    initial begin
        repeat (3) step();
        chk_reset_outputs("reset_initial");
        reset = 1'b0;
        step();

        // Display starts cleared; 12AF only pends until the boundary.
        check_frame("boot", {S0, S0, S0, S0}, 4'b1111, 0, 0, 16'h12AF, 4'b0000, 4'b0000, 1'b0);
        // Mid-frame load of 1111 must not disturb digits 2 and 3 of this frame.
        check_frame("hex_12AF", {S1, S2, SA, SF}, 4'b1111, 1, 3, 16'h1111, 4'b0000, 4'b0000, 1'b0);
        check_frame("hex_1111", {S1, S1, S1, S1}, 4'b1111, 2, 5, 16'h0050, 4'b0000, 4'b0000, 1'b1);
        check_frame("lz_0050", {OFF, OFF, S5, S0}, 4'b1111, 0, 4, 16'h0000, 4'b0000, 4'b0000, 1'b1);
        // Load on the wrap cycle itself must show in the very next frame.
        check_frame("lz_0000", {OFF, OFF, OFF, S0}, 4'b1111, 3, 6, 16'h1234, 4'b0100, 4'b0010, 1'b0);
        check_frame("blank_dp", {S1, S2, OFF, S4}, 4'b1011, -1, -1, 16'h0000, 4'b0000, 4'b0000, 1'b0);

        repeat (11) step();
        reset = 1'b1;
        #1;
        chk_reset_outputs("reset_async");
        step();
        step();
        chk_reset_outputs("reset_held");
        reset = 1'b0;
        step();
        check_frame("after_reset", {S0, S0, S0, S0}, 4'b1111, -1, -1, 16'h0000, 4'b0000, 4'b0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seven_seg_mux.md
SEVEN_SEG_MUX -- requirements
Module: seven_seg_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clock cycles per digit slot (>= 4).
REQ-003 SHALL have parameter GUARD, default 2, cycles at slot start with all anodes off (< REFRESH_DIV).
REQ-004 SHALL have parameter ACTIVE_LOW_AN, default 1, anode polarity (1 = low enables digit).
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 SHALL have port clk  input  1  rising-edge system clock.
REQ-007 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-008 SHALL have port value  input  4*NUM_DIGITS  hex nibbles, digit 0 in bits [3:0].
REQ-009 SHALL have port dp  input  NUM_DIGITS  decimal-point request per digit.
REQ-010 SHALL have port blank  input  NUM_DIGITS  force digit dark.
REQ-011 SHALL have port lz_en  input  1  leading-zero suppression enable.
REQ-012 SHALL have port load  input  1  one-cycle strobe capturing value/dp/blank/lz_en.
REQ-013 SHALL have port segments  output  7  active-low gfe_dcba pattern.
REQ-014 SHALL have port dp_out  output  1  active-low decimal point.
REQ-015 SHALL have port anodes  output  NUM_DIGITS  one-hot digit enable, polarity per ACTIVE_LOW_AN.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse at end of last digit slot.

Function
REQ-017 SHALL capture inputs into a pending register on any cycle load=1; last load before a frame boundary wins.
REQ-018 SHALL copy pending to the display register only at the frame boundary (digit index wraps NUM_DIGITS-1 -> 0), so no frame shows mixed data.
REQ-019 SHALL run prescaler 0..REFRESH_DIV-1; at terminal count, advance digit index by 1, wrapping to 0 after NUM_DIGITS-1.
REQ-020 SHALL assert frame_done for exactly the cycle the index wraps, coincident with the display-register update.
REQ-021 SHALL drive all anodes inactive while prescaler < GUARD; otherwise enable only the current digit.
REQ-022 SHALL decode nibble 0-F to patterns 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110.
REQ-023 SHALL treat a digit as dark (segments=1111111, dp_out=1) when its blank bit is set, or when lz_en=1 and it and all higher digits are zero and it is not digit 0.
REQ-024 SHALL force dp_out=1 on dark digits; otherwise dp_out = ~dp[index].
REQ-025 SHALL register segments, dp_out and anodes; outputs reflect index and prescaler with 1-cycle latency, guard window included.
REQ-026 SHALL, for load coincident with the frame boundary, apply the newly loaded data in that same update.

Reset
REQ-027 SHALL, on reset, clear prescaler, index, pending and display registers to zero, including blank and lz_en.
REQ-028 SHALL, on reset, drive segments=1111111, dp_out=1, anodes all inactive, frame_done=0.
REQ-029 SHALL, after reset release, begin at digit 0, prescaler 0; reset mid-frame abandons the frame without a frame_done pulse.

Structure
REQ-030 SHALL place the 16-entry segment table, the DIGIT_W=4 constant and the SEG_OFF=7'b1111111 constant in package seven_seg_pkg.
REQ-031 SHALL implement nibble decoding in a combinational sub-module hex_to_seg, instantiated once on the muxed nibble.

Verification
REQ-032 SHALL verify: NUM_DIGITS=4, REFRESH_DIV=8, load value=16'h12AF -> digits 0..3 show 0001110, 0001000, 0100100, 1111001, each slot 8 cycles.
REQ-033 SHALL verify: lz_en=1, value=16'h0050 -> digits 3,2 dark; digit 1=0010010; digit 0=1000000.
REQ-034 SHALL verify: value=16'h0000 with lz_en=1 -> digit 0 shows 1000000; others dark.
REQ-035 SHALL verify: load 16'h1111 mid-frame -> old value held until frame_done, new value from the next digit 0.
REQ-036 SHALL verify: GUARD=2 -> anodes inactive for the first 2 cycles of every slot; dp=4'b0100 -> dp_out=0 only on digit 2.
REQ-037 SHALL verify: reset asserted mid-slot -> outputs immediately at reset values; after release, digit 0 restarts with full guard window.
